// File: rtl/pol_map_ser_pkg.sv
// Shared definitions for the pooling map serializer: default widths, FSM encoding, helpers.
package pol_map_ser_pkg;

    // Parameter defaults for the serializer and its slicer
    localparam int unsigned DEF_IDX_WIDTH            = 10;
    localparam int unsigned DEF_POOL_MAP_DEPTH_WIDTH = 5;
    localparam int unsigned DEF_ADDR_WIDTH           = 12;
    localparam int unsigned DEF_MAX_OUTSTD           = 2;

    // Job FSM encoding
    localparam int unsigned POL_STATE_W = 2;

    typedef enum logic [POL_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } polState_t;

    // In-flight read counter width; covers 0..4 outstanding reads
    localparam int unsigned INFLIGHT_W = 3;

    // Number of neighbour indices packed into one map word
    function automatic int unsigned mapIdxNum(input int unsigned depthWidth);
        return 32'(1) << depthWidth;
    endfunction

endpackage : pol_map_ser_pkg

// File: rtl/pol_map_slicer.sv
// Holds one map word and walks its first K neighbour indices towards the pooling core.
module pol_map_slicer
    import pol_map_ser_pkg::*;
#(
    parameter  int unsigned IDX_WIDTH            = DEF_IDX_WIDTH,
    parameter  int unsigned POOL_MAP_DEPTH_WIDTH = DEF_POOL_MAP_DEPTH_WIDTH,
    localparam int unsigned MAP_IDX_NUM          = mapIdxNum(POOL_MAP_DEPTH_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [POOL_MAP_DEPTH_WIDTH-1:0]  cfgK,
    input  logic                             wordLoad,
    input  logic [IDX_WIDTH*MAP_IDX_NUM-1:0] wordIn,
    input  logic                             idxRdy,
    output logic [IDX_WIDTH-1:0]             idx,
    output logic                             idxVld,
    output logic                             lastIdxHs
);

    logic [MAP_IDX_NUM-1:0][IDX_WIDTH-1:0] wordReg;
    logic                                  wordVld;
    logic [POOL_MAP_DEPTH_WIDTH-1:0]       kCnt;
    logic                                  kLast;
    logic                                  idxHs;

    // Handshake decode; the last slice of a word frees the word register
    always_comb begin
        kLast     = (kCnt == (cfgK - POOL_MAP_DEPTH_WIDTH'(1)));
        idxHs     = wordVld & idxRdy;
        lastIdxHs = idxHs & kLast;
    end

    // Slice mux; index j of the word sits at bits [j*IDX_WIDTH +: IDX_WIDTH]
    always_comb begin
        idx    = wordReg[kCnt];
        idxVld = wordVld;
    end

    // Word register: a load in the same cycle as the last slice keeps the stream gapless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wordReg <= '0;
            wordVld <= 1'b0;
        end else begin
            if (wordLoad) begin
                wordReg <= wordIn;
                wordVld <= 1'b1;
            end else if (lastIdxHs) begin
                wordVld <= 1'b0;
            end
        end
    end

    // Slice counter: advances per accepted index, wraps after slice K-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kCnt <= '0;
        end else if (idxHs) begin
            kCnt <= kLast ? '0 : kCnt + POOL_MAP_DEPTH_WIDTH'(1);
        end
    end

endmodule : pol_map_slicer

// File: rtl/pol_map_ser.sv
// Pooling map serializer: fetches one map word per point and streams its K neighbour indices.
module pol_map_ser
    import pol_map_ser_pkg::*;
#(
    parameter  int unsigned IDX_WIDTH            = DEF_IDX_WIDTH,
    parameter  int unsigned POOL_MAP_DEPTH_WIDTH = DEF_POOL_MAP_DEPTH_WIDTH,
    parameter  int unsigned ADDR_WIDTH           = DEF_ADDR_WIDTH,
    parameter  int unsigned MAX_OUTSTD           = DEF_MAX_OUTSTD,
    localparam int unsigned MAP_IDX_NUM          = mapIdxNum(POOL_MAP_DEPTH_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    // job configuration
    input  logic                             CfgVld,
    output logic                             CfgRdy,
    input  logic [POOL_MAP_DEPTH_WIDTH-1:0]  CfgK,
    input  logic [IDX_WIDTH-1:0]             CfgNip,
    input  logic [ADDR_WIDTH-1:0]            CfgBaseAddr,
    // map buffer read address
    output logic [ADDR_WIDTH-1:0]            MapRdAddr,
    output logic                             MapRdAddrVld,
    input  logic                             MapRdAddrRdy,
    // map buffer read data
    input  logic [IDX_WIDTH*MAP_IDX_NUM-1:0] MapRdDat,
    input  logic                             MapRdDatVld,
    output logic                             MapRdDatRdy,
    // neighbour index stream
    output logic [IDX_WIDTH-1:0]             Idx,
    output logic                             IdxVld,
    input  logic                             IdxRdy,
    // job completion
    output logic                             Done
);

    polState_t                       state;
    polState_t                       stateNxt;

    logic [POOL_MAP_DEPTH_WIDTH-1:0] kReg;
    logic [IDX_WIDTH-1:0]            nipReg;
    logic [ADDR_WIDTH-1:0]           baseReg;
    logic [IDX_WIDTH-1:0]            addrCnt;
    logic [IDX_WIDTH-1:0]            ptCnt;
    logic [INFLIGHT_W-1:0]           inflight;

    logic                            cfgAcc;
    logic                            addrHs;
    logic                            datHs;
    logic                            lastIdxHs;
    logic                            lastPt;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        stateNxt     = state;
        CfgRdy       = 1'b0;
        Done         = 1'b0;
        MapRdAddrVld = 1'b0;
        unique case (state)
            ST_IDLE: begin
                CfgRdy = 1'b1;
                if (CfgVld) begin
                    // an empty job completes without touching the map buffer
                    stateNxt = ((CfgNip == '0) || (CfgK == '0)) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                MapRdAddrVld = (addrCnt < nipReg) && (inflight < INFLIGHT_W'(MAX_OUTSTD));
                if (lastIdxHs && lastPt) begin
                    stateNxt = ST_DONE;
                end
            end
            ST_DONE: begin
                Done     = 1'b1;
                stateNxt = ST_IDLE;
            end
            default: begin
                stateNxt = ST_IDLE;
            end
        endcase
    end

    // Handshake decode; data with no read in flight is a stray beat and is dropped
    always_comb begin
        cfgAcc      = CfgVld & CfgRdy;
        addrHs      = MapRdAddrVld & MapRdAddrRdy;
        MapRdDatRdy = ~IdxVld | lastIdxHs;
        datHs       = MapRdDatVld & MapRdDatRdy & (inflight != '0);
        lastPt      = (ptCnt == (nipReg - IDX_WIDTH'(1)));
        MapRdAddr   = baseReg + ADDR_WIDTH'(addrCnt);
    end

    // Job configuration capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kReg    <= '0;
            nipReg  <= '0;
            baseReg <= '0;
        end else if (cfgAcc) begin
            kReg    <= CfgK;
            nipReg  <= CfgNip;
            baseReg <= CfgBaseAddr;
        end
    end

    // Read-address and completed-point counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrCnt <= '0;
            ptCnt   <= '0;
        end else if (cfgAcc) begin
            addrCnt <= '0;
            ptCnt   <= '0;
        end else begin
            if (addrHs) begin
                addrCnt <= addrCnt + IDX_WIDTH'(1);
            end
            if (lastIdxHs) begin
                ptCnt <= ptCnt + IDX_WIDTH'(1);
            end
        end
    end

    // Outstanding read tracking; a simultaneous issue and return leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (cfgAcc) begin
            inflight <= '0;
        end else begin
            unique case ({addrHs, datHs})
                2'b10:   inflight <= inflight + INFLIGHT_W'(1);
                2'b01:   inflight <= inflight - INFLIGHT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Word register, slice counter and slice mux
    pol_map_slicer #(
        .IDX_WIDTH            (IDX_WIDTH),
        .POOL_MAP_DEPTH_WIDTH (POOL_MAP_DEPTH_WIDTH)
    ) uSlicer (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfgK      (kReg),
        .wordLoad  (datHs),
        .wordIn    (MapRdDat),
        .idxRdy    (IdxRdy),
        .idx       (Idx),
        .idxVld    (IdxVld),
        .lastIdxHs (lastIdxHs)
    );

endmodule : pol_map_ser

// File: tb/tb_pol_map_ser.sv
// Scoreboard bench for pol_map_ser with a 1-cycle-latency map memory model.
module tb_pol_map_ser;

    localparam int unsigned IW = 10;
    localparam int unsigned DW = 5;
    localparam int unsigned AW = 12;
    localparam int unsigned MO = 2;
    localparam int unsigned NI = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             CfgVld;
    logic             CfgRdy;
    logic [DW-1:0]    CfgK;
    logic [IW-1:0]    CfgNip;
    logic [AW-1:0]    CfgBaseAddr;
    logic [AW-1:0]    MapRdAddr;
    logic             MapRdAddrVld;
    logic             MapRdAddrRdy;
    logic [IW*NI-1:0] MapRdDat;
    logic             MapRdDatVld;
    logic             MapRdDatRdy;
    logic [IW-1:0]    Idx;
    logic             IdxVld;
    logic             IdxRdy;
    logic             Done;

    always #5 clk = ~clk;

    pol_map_ser #(
        .IDX_WIDTH            (IW),
        .POOL_MAP_DEPTH_WIDTH (DW),
        .ADDR_WIDTH           (AW),
        .MAX_OUTSTD           (MO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .CfgVld       (CfgVld),
        .CfgRdy       (CfgRdy),
        .CfgK         (CfgK),
        .CfgNip       (CfgNip),
        .CfgBaseAddr  (CfgBaseAddr),
        .MapRdAddr    (MapRdAddr),
        .MapRdAddrVld (MapRdAddrVld),
        .MapRdAddrRdy (MapRdAddrRdy),
        .MapRdDat     (MapRdDat),
        .MapRdDatVld  (MapRdDatVld),
        .MapRdDatRdy  (MapRdDatRdy),
        .Idx          (Idx),
        .IdxVld       (IdxVld),
        .IdxRdy       (IdxRdy),
        .Done         (Done)
    );

    int nCmp = 0;
    int nErr = 0;

    logic [IW-1:0] expIdx[$];
    logic [AW-1:0] expAddr[$];
    logic [AW-1:0] pend[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Map memory contents: index j of the word at address a
    function automatic logic [IW-1:0] memIdx(input logic [AW-1:0] a, input int j);
        return IW'(32'(a) * 32'd37 + 32'(j) * 32'd11 + 32'd5);
    endfunction

    function automatic logic [IW*NI-1:0] memWord(input logic [AW-1:0] a);
        logic [IW*NI-1:0] w;
        w = '0;
        for (int j = 0; j < int'(NI); j++) w[j*IW +: IW] = memIdx(a, j);
        return w;
    endfunction

    task automatic checkResetOutputs(input string pfx);
        checkVal({pfx, "_addrVld"}, 32'(MapRdAddrVld), 32'd0);
        checkVal({pfx, "_datRdy"},  32'(MapRdDatRdy),  32'd1);
        checkVal({pfx, "_idxVld"},  32'(IdxVld),       32'd0);
        checkVal({pfx, "_done"},    32'(Done),         32'd0);
        checkVal({pfx, "_addr"},    32'(MapRdAddr),    32'd0);
        checkVal({pfx, "_idx"},     32'(Idx),          32'd0);
    endtask

    // One job: drive config, serve reads, score addresses and indices, check Done timing
    task automatic runJob(input int k, input int nip, input logic [AW-1:0] base,
                          input bit toggleRdy, input int stallFrom, input int stallLen,
                          input bit cfgNoise, input bit noBubbles, input int rstAfter);
        int cyc = 0, lastIdxCyc = 0, doneCyc = 0, doneCnt = 0;
        int idxCnt = 0, addrCnt = 0, firstDatCyc = 0, bubbles = 0, maxOut = 0;
        int expReads, expTotal;
        bit fin = 0, aborted = 0, seenIdx = 0, prevIdxStall = 0, prevAddrStall = 0;
        logic [IW-1:0] prevIdx = '0;
        logic [AW-1:0] prevAddr = '0;

        @(negedge clk);
        CfgVld       = 1'b1;
        CfgK         = DW'(k);
        CfgNip       = IW'(nip);
        CfgBaseAddr  = base;
        IdxRdy       = 1'b1;
        MapRdAddrRdy = 1'b1;
        MapRdDatVld  = 1'b0;
        #1;
        checkVal("cfgRdyIdle", 32'(CfgRdy), 32'd1);
        expReads = (k == 0 || nip == 0) ? 0 : nip;
        expTotal = expReads * k;
        for (int p = 0; p < expReads; p++) begin
            expAddr.push_back(base + AW'(p));
            for (int j = 0; j < k; j++) expIdx.push_back(memIdx(base + AW'(p), j));
        end
        @(posedge clk);

        while (!fin) begin
            @(negedge clk);
            cyc++;
            CfgVld       = cfgNoise && (doneCnt == 0) && !Done;
            CfgK         = DW'(7);
            CfgNip       = IW'(99);
            CfgBaseAddr  = 12'h123;
            IdxRdy       = toggleRdy ? ((cyc % 2) == 1) : 1'b1;
            MapRdAddrRdy = !((cyc >= stallFrom) && (cyc < stallFrom + stallLen));
            MapRdDatVld  = (pend.size() > 0);
            MapRdDat     = (pend.size() > 0) ? memWord(pend[0]) : '0;
            #1;

            if (cyc == 1) begin
                checkVal("cfgRdyBusy", 32'(CfgRdy), 32'd0);
                if (expReads > 0) checkVal("firstAddrVld", 32'(MapRdAddrVld), 32'd1);
            end
            if (expReads == 0) checkVal("noAddrVld", 32'(MapRdAddrVld), 32'd0);
            if (prevIdxStall) begin
                checkVal("idxVldHold", 32'(IdxVld), 32'd1);
                checkVal("idxHold", 32'(Idx), 32'(prevIdx));
            end
            if (prevAddrStall) begin
                checkVal("addrVldHold", 32'(MapRdAddrVld), 32'd1);
                checkVal("addrHold", 32'(MapRdAddr), 32'(prevAddr));
            end
            if (firstDatCyc > 0 && cyc == firstDatCyc + 1)
                checkVal("firstIdxLat", 32'(IdxVld), 32'd1);
            if (seenIdx && idxCnt < expTotal && !IdxVld) bubbles++;
            if (IdxVld) seenIdx = 1;

            // handshakes that the coming rising edge will commit
            if (MapRdDatVld && MapRdDatRdy) begin
                void'(pend.pop_front());
                if (firstDatCyc == 0) firstDatCyc = cyc;
            end
            if (MapRdAddrVld && MapRdAddrRdy) begin
                if (expAddr.size() == 0) checkVal("addrExtra", 32'd1, 32'd0);
                else checkVal("addr", 32'(MapRdAddr), 32'(expAddr.pop_front()));
                pend.push_back(MapRdAddr);
                addrCnt++;
            end
            if (pend.size() > maxOut) maxOut = pend.size();
            if (IdxVld && IdxRdy) begin
                if (expIdx.size() == 0) checkVal("idxExtra", 32'd1, 32'd0);
                else checkVal("idx", 32'(Idx), 32'(expIdx.pop_front()));
                idxCnt++;
                lastIdxCyc = cyc;
            end
            if (Done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            prevIdxStall  = IdxVld && !IdxRdy;
            prevIdx       = Idx;
            prevAddrStall = MapRdAddrVld && !MapRdAddrRdy;
            prevAddr      = MapRdAddr;

            if (rstAfter > 0 && idxCnt == rstAfter) begin
                rst_n = 1'b0;
                #1;
                checkResetOutputs("midRst");
                expIdx.delete();
                expAddr.delete();
                pend.delete();
                MapRdDatVld = 1'b0;
                CfgVld      = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                checkVal("cfgRdyAfterRst", 32'(CfgRdy), 32'd1);
                aborted = 1;
                fin     = 1;
            end else if (doneCnt > 0 && cyc == doneCyc + 1) begin
                checkVal("doneLow", 32'(Done), 32'd0);
                checkVal("cfgRdyBack", 32'(CfgRdy), 32'd1);
                fin = 1;
            end else if (cyc > 3000) begin
                checkVal("jobTimeout", 32'd0, 32'd1);
                fin = 1;
            end
        end

        CfgVld = 1'b0;
        if (!aborted) begin
            checkVal("doneCnt", 32'(doneCnt), 32'd1);
            checkVal("doneTiming", 32'(doneCyc), 32'(lastIdxCyc + 1));
            checkVal("idxCnt", 32'(idxCnt), 32'(expTotal));
            checkVal("addrCnt", 32'(addrCnt), 32'(expReads));
            checkVal("maxInflight", 32'(maxOut <= int'(MO)), 32'd1);
            checkVal("idxLeft", 32'(expIdx.size()), 32'd0);
            if (noBubbles) checkVal("bubbles", 32'(bubbles), 32'd0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        CfgVld       = 1'b0;
        CfgK         = '0;
        CfgNip       = '0;
        CfgBaseAddr  = '0;
        MapRdAddrRdy = 1'b1;
        MapRdDat     = '0;
        MapRdDatVld  = 1'b0;
        IdxRdy       = 1'b1;
        #1;
        checkResetOutputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("cfgRdyRst", 32'(CfgRdy), 32'd1);

        runJob(3,  2, 12'h010, 1'b0, 0, 0, 1'b0, 1'b1, 0);   // basic, back-to-back words
        runJob(31, 4, 12'h200, 1'b1, 0, 0, 1'b1, 1'b0, 0);   // toggling IdxRdy, config ignored while busy
        runJob(5,  0, 12'h020, 1'b0, 0, 0, 1'b0, 1'b0, 0);   // empty: no points
        runJob(0,  5, 12'h030, 1'b0, 0, 0, 1'b0, 1'b0, 0);   // empty: no neighbours
        runJob(1,  8, 12'h040, 1'b0, 1, 5, 1'b0, 1'b1, 0);   // address stall, then gapless stream
        runJob(2,  3, 12'hFFF, 1'b0, 0, 0, 1'b0, 1'b1, 0);   // address wrap
        runJob(3,  4, 12'h300, 1'b0, 0, 0, 1'b0, 1'b0, 2);   // reset mid-job
        runJob(2,  1, 12'h055, 1'b0, 0, 0, 1'b0, 1'b1, 0);   // recovery after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pol_map_ser

// File: doc/pol_map_ser.md
POL_MAP_SER -- requirements
Module: pol_map_ser

Interface
REQ-001 SHALL take parameter IDX_WIDTH, default 10, width of one neighbour index and of the point count.
REQ-002 SHALL take parameter POOL_MAP_DEPTH_WIDTH, default 5, width of CfgK; MAP_IDX_NUM = 2**POOL_MAP_DEPTH_WIDTH indices per map word.
REQ-003 SHALL take parameter ADDR_WIDTH, default 12, map-buffer word address width.
REQ-004 SHALL take parameter MAX_OUTSTD, default 2, maximum map reads in flight, range 1..4.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  async reset, active low.
REQ-006 CfgVld  in  1  configuration valid; CfgRdy  out  1  block idle, accepts config.
REQ-007 CfgK  in  POOL_MAP_DEPTH_WIDTH  neighbours per point, legal 0..MAP_IDX_NUM-1; CfgNip  in  IDX_WIDTH  number of points.
REQ-008 CfgBaseAddr  in  ADDR_WIDTH  map word address of point 0.
REQ-009 MapRdAddr  out  ADDR_WIDTH  read address; MapRdAddrVld  out  1; MapRdAddrRdy  in  1.
REQ-010 MapRdDat  in  IDX_WIDTH*MAP_IDX_NUM  map word, index j at bits [j*IDX_WIDTH +: IDX_WIDTH]; MapRdDatVld  in  1; MapRdDatRdy  out  1.
REQ-011 Idx  out  IDX_WIDTH  neighbour index to pooling core; IdxVld  out  1; IdxRdy  in  1.
REQ-012 Done  out  1  one-cycle pulse, job complete.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; CfgRdy = (state==IDLE).
REQ-014 On CfgVld&CfgRdy SHALL latch CfgK, CfgNip, CfgBaseAddr and go to RUN; if CfgNip==0 or CfgK==0, SHALL go directly to DONE with no reads issued and no Idx emitted.
REQ-015 In RUN, SHALL present MapRdAddr = base + addr_cnt with MapRdAddrVld=1 while addr_cnt < Nip and inflight < MAX_OUTSTD; addr_cnt increments on the MapRdAddrVld&MapRdAddrRdy handshake; addresses wrap modulo 2**ADDR_WIDTH.
REQ-016 inflight SHALL increment on address handshake, decrement on data handshake, and hold on simultaneous occurrence of both.
REQ-017 Read data returns in order; SHALL hold one map word in a word register; MapRdDatRdy = !word_vld | last_idx_hs, where last_idx_hs = IdxVld&IdxRdy&(k==K-1).
REQ-018 Idx SHALL equal slice k of the held word, IdxVld = word_vld; k increments per Idx handshake and clears to 0 at k==K-1.
REQ-019 Data handshake in the same cycle as last_idx_hs SHALL load the new word with zero bubble (back-to-back points produce continuous IdxVld).
REQ-020 Idx and IdxVld SHALL hold stable while IdxVld&!IdxRdy; MapRdAddr likewise while MapRdAddrVld&!MapRdAddrRdy.
REQ-021 pt_cnt SHALL increment on last_idx_hs; when last_idx_hs occurs with pt_cnt==Nip-1, SHALL move to DONE.
REQ-022 DONE SHALL last exactly one cycle with Done=1, then IDLE; CfgVld during RUN/DONE is ignored (CfgRdy=0).
REQ-023 Latency: first MapRdAddrVld the cycle after config acceptance; first IdxVld the cycle after the first data handshake.
REQ-024 MapRdDatVld while MapRdDatRdy=0 SHALL NOT be consumed; MapRdDatVld with inflight==0 is an upstream protocol error, ignored.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, all counters and inflight 0, word_vld 0; outputs CfgRdy=1 after release, MapRdAddrVld=0, MapRdDatRdy=1, IdxVld=0, Done=0, MapRdAddr=CfgBaseAddr-independent 0, Idx=0.
REQ-026 Reset mid-RUN SHALL abandon the job; in-flight read data arriving after reset is ignored by the bench contract (memory is reset with the block).

Structure
REQ-027 MAP_IDX_NUM, FSM state encoding and widths SHALL live in the shared POL package.
REQ-028 One sub-module SHALL be used: pol_map_slicer (word register, k counter, slice mux, last flag); address/inflight/point logic stays in pol_map_ser.

Verification
REQ-029 K=3, Nip=2, base=0x10, all ready=1, memory 1-cycle latency -> reads 0x10,0x11; Idx = word0[0..2], word1[0..2]; Done 1 cycle after 6th Idx handshake.
REQ-030 K=31, Nip=4, IdxRdy toggled every cycle -> 124 Idx in order, no drop/duplicate, inflight never >2, Idx stable while stalled.
REQ-031 CfgNip=0 (then CfgK=0, Nip=5) -> no MapRdAddrVld, Done pulse the cycle after acceptance, back to CfgRdy=1.
REQ-032 K=1, Nip=8, MapRdAddrRdy low 5 cycles mid-job -> addresses held, 8 continuous Idx after resume, zero bubbles between points.
REQ-033 base=0xFFF, Nip=3 -> addresses 0xFFF,0x000,0x001.
REQ-034 rst_n asserted during RUN after 2 Idx -> all outputs at reset values immediately; new config K=2, Nip=1 completes normally.
